// File: rtl/rr_grant_ctrl_if.sv
`default_nettype none
// ============================================================================
//  Module      : rr_grant_ctrl_if
//  Description : Request/grant bundle between four requesters and the
//                round-robin grant controller.
//  Revision    : 1.0 - initial release
// ============================================================================
interface rr_grant_ctrl_if;
    logic [3:0] req;
    logic       done;
    logic [3:0] gnt;
    logic [1:0] gnt_id;
    logic       gnt_valid;
    logic       timeout;

    // Requester side drives req/done and observes the grant.
    modport master (
        output req,
        output done,
        input  gnt,
        input  gnt_id,
        input  gnt_valid,
        input  timeout
    );

    // Arbiter side.
    modport slave (
        input  req,
        input  done,
        output gnt,
        output gnt_id,
        output gnt_valid,
        output timeout
    );
endinterface
`default_nettype wire

// File: rtl/rr_grant_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : rr_grant_ctrl
//  Description : Four-way round-robin arbiter with per-grant hold limit and a
//                one-cycle gap between consecutive grants.
//  Revision    : 1.0 - initial release
// ============================================================================
module rr_grant_ctrl #(
    parameter int MAX_HOLD = 15
) (
    input  wire logic     clk_i,
    input  wire logic     rst_ni,
    rr_grant_ctrl_if.slave bus
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        GRANT = 2'd1,
        GAP   = 2'd2
    } state_t;

    localparam logic [7:0] HOLD_LAST = 8'(MAX_HOLD - 1);

    state_t     state_q, state_d;
    logic [1:0] ptr_q, ptr_d;
    logic [7:0] hold_cnt_q, hold_cnt_d;
    logic [3:0] gnt_q, gnt_d;
    logic [1:0] gnt_id_q, gnt_id_d;
    logic       gnt_valid_q, gnt_valid_d;
    logic       timeout_q, timeout_d;

    logic       w_win_found;
    logic [1:0] w_win_idx;
    logic       w_release;
    logic       w_hold_expired;

    // Search ptr+1 .. ptr+4 (wrapping), so the last grantee ranks lowest.
    always_comb begin
        logic [1:0] cand;
        w_win_found = 1'b0;
        w_win_idx   = ptr_q;
        cand        = ptr_q;
        for (int k = 1; k <= 4; k++) begin
            cand = ptr_q + 2'(k);
            if (!w_win_found && bus.req[cand]) begin
                w_win_found = 1'b1;
                w_win_idx   = cand;
            end
        end
    end

    assign w_release      = bus.done || !bus.req[gnt_id_q];
    assign w_hold_expired = (hold_cnt_q == HOLD_LAST);

    always_comb begin
        state_d     = state_q;
        ptr_d       = ptr_q;
        hold_cnt_d  = hold_cnt_q;
        gnt_d       = gnt_q;
        gnt_id_d    = gnt_id_q;
        gnt_valid_d = gnt_valid_q;
        timeout_d   = 1'b0;

        case (state_q)
            IDLE, GAP: begin
                if (w_win_found) begin
                    state_d     = GRANT;
                    gnt_d       = 4'b0001 << w_win_idx;
                    gnt_id_d    = w_win_idx;
                    gnt_valid_d = 1'b1;
                    ptr_d       = w_win_idx;
                    hold_cnt_d  = 8'd0;
                end else begin
                    state_d     = IDLE;
                    gnt_d       = 4'b0000;
                    gnt_valid_d = 1'b0;
                end
            end
            GRANT: begin
                // Release outranks the hold limit, so a coincident expiry
                // produces no timeout pulse.
                if (w_release) begin
                    state_d     = GAP;
                    gnt_d       = 4'b0000;
                    gnt_valid_d = 1'b0;
                end else if (w_hold_expired) begin
                    state_d     = GAP;
                    gnt_d       = 4'b0000;
                    gnt_valid_d = 1'b0;
                    timeout_d   = 1'b1;
                end else begin
                    hold_cnt_d  = hold_cnt_q + 8'd1;
                end
            end
            default: begin
                state_d     = IDLE;
                gnt_d       = 4'b0000;
                gnt_valid_d = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            state_q     <= IDLE;
            ptr_q       <= 2'd3;
            hold_cnt_q  <= 8'd0;
            gnt_q       <= 4'b0000;
            gnt_id_q    <= 2'd0;
            gnt_valid_q <= 1'b0;
            timeout_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            ptr_q       <= ptr_d;
            hold_cnt_q  <= hold_cnt_d;
            gnt_q       <= gnt_d;
            gnt_id_q    <= gnt_id_d;
            gnt_valid_q <= gnt_valid_d;
            timeout_q   <= timeout_d;
        end
    end

    assign bus.gnt       = gnt_q;
    assign bus.gnt_id    = gnt_id_q;
    assign bus.gnt_valid = gnt_valid_q;
    assign bus.timeout   = timeout_q;

endmodule
`default_nettype wire
